// File: rtl/ring_mem_responder.sv
// ring_mem_responder: ring stop with a 64x32 local memory.
// Request and response rings both pass through two register stages (Q500->Q501->Q502).
// A request is consumed when it is addressed to this stop, is a RD or WR, and the
// response FIFO has room. A consumed request:
//   - leaves an invalidated slot on the request ring;
//   - accesses memory;
//   - queues a response in a 4-entry FIFO.
// The FIFO head is placed into the next empty response-ring slot.
// Optional build macro RING_RSP_ADDR_CHK_EN: targeted requests with Address[23:8]!=0
// skip memory and return 32'hBADA_DD00. When the macro is undefined, those bits are
// ignored and the memory aliases.
module ring_mem_responder (
   input  logic        QClk,
   input  logic        RstQnnnH,
   input  logic [7:0]  CoreID,
   input  logic        RingReqInValidQ500H,
   input  logic [9:0]  RingReqInRequestorQ500H,
   input  logic [2:0]  RingReqInOpcodeQ500H,
   input  logic [31:0] RingReqInAddressQ500H,
   input  logic [31:0] RingReqInDataQ500H,
   input  logic        RingRspInValidQ500H,
   input  logic [9:0]  RingRspInRequestorQ500H,
   input  logic [2:0]  RingRspInOpcodeQ500H,
   input  logic [31:0] RingRspInAddressQ500H,
   input  logic [31:0] RingRspInDataQ500H,
   output logic        RingReqOutValidQ502H,
   output logic [9:0]  RingReqOutRequestorQ502H,
   output logic [2:0]  RingReqOutOpcodeQ502H,
   output logic [31:0] RingReqOutAddressQ502H,
   output logic [31:0] RingReqOutDataQ502H,
   output logic        RingRspOutValidQ502H,
   output logic [9:0]  RingRspOutRequestorQ502H,
   output logic [2:0]  RingRspOutOpcodeQ502H,
   output logic [31:0] RingRspOutAddressQ502H,
   output logic [31:0] RingRspOutDataQ502H
);

   localparam logic [2:0] OP_RD     = 3'd1;
   localparam logic [2:0] OP_WR     = 3'd2;
   localparam logic [2:0] OP_RD_RSP = 3'd3;
   localparam logic [2:0] OP_WR_RSP = 3'd4;
`ifdef RING_RSP_ADDR_CHK_EN
   localparam logic [31:0] ADDR_ERR_DATA = 32'hBADA_DD00;
`endif

   logic [31:0] mem [64];

   logic        req_v_q501;
   logic [9:0]  req_rqr_q501;
   logic [2:0]  req_op_q501;
   logic [31:0] req_addr_q501;
   logic [31:0] req_data_q501;
   logic        rsp_v_q501;
   logic [9:0]  rsp_rqr_q501;
   logic [2:0]  rsp_op_q501;
   logic [31:0] rsp_addr_q501;
   logic [31:0] rsp_data_q501;
   logic        wr_en_q501;
   logic [5:0]  wr_idx_q501;
   logic [31:0] wr_data_q501;

   logic [9:0]  fifo_rqr  [4];
   logic [2:0]  fifo_op   [4];
   logic [31:0] fifo_addr [4];
   logic [31:0] fifo_data [4];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic [2:0]  fifo_cnt;

   logic        pop;
   logic        consume;
   logic        is_wr;
   logic        addr_err;
   logic [5:0]  idx;
   logic [31:0] rd_data;
   logic [31:0] push_data;

   // Consume decision for the Q500 request; room counts the pop happening this same cycle.
   always_comb begin
      pop      = 1'b0;
      consume  = 1'b0;
      is_wr    = (RingReqInOpcodeQ500H == OP_WR);
      addr_err = 1'b0;
      idx      = RingReqInAddressQ500H[7:2];
      rd_data  = mem[idx];
      pop      = !rsp_v_q501 && (fifo_cnt != 3'd0);
      consume  = RingReqInValidQ500H
                 && (RingReqInAddressQ500H[31:24] == CoreID)
                 && ((RingReqInOpcodeQ500H == OP_RD) || is_wr)
                 && ((fifo_cnt != 3'd4) || pop);
`ifdef RING_RSP_ADDR_CHK_EN
      addr_err = |RingReqInAddressQ500H[23:8];
`endif
      // The previous request's write lands at the end of this cycle; forward it.
      if (wr_en_q501 && (wr_idx_q501 == idx)) rd_data = wr_data_q501;
      push_data = is_wr ? RingReqInDataQ500H : rd_data;
`ifdef RING_RSP_ADDR_CHK_EN
      if (addr_err) push_data = ADDR_ERR_DATA;
`endif
   end

   // Ring pipeline, pending memory write and FIFO pointers.
   always_ff @(posedge QClk) begin
      if (RstQnnnH) begin
         req_v_q501               <= 1'b0;
         req_rqr_q501             <= '0;
         req_op_q501              <= '0;
         req_addr_q501            <= '0;
         req_data_q501            <= '0;
         rsp_v_q501               <= 1'b0;
         rsp_rqr_q501             <= '0;
         rsp_op_q501              <= '0;
         rsp_addr_q501            <= '0;
         rsp_data_q501            <= '0;
         wr_en_q501               <= 1'b0;
         wr_idx_q501              <= '0;
         wr_data_q501             <= '0;
         RingReqOutValidQ502H     <= 1'b0;
         RingReqOutRequestorQ502H <= '0;
         RingReqOutOpcodeQ502H    <= '0;
         RingReqOutAddressQ502H   <= '0;
         RingReqOutDataQ502H      <= '0;
         RingRspOutValidQ502H     <= 1'b0;
         RingRspOutRequestorQ502H <= '0;
         RingRspOutOpcodeQ502H    <= '0;
         RingRspOutAddressQ502H   <= '0;
         RingRspOutDataQ502H      <= '0;
         wr_ptr                   <= '0;
         rd_ptr                   <= '0;
         fifo_cnt                 <= '0;
      end else begin
         req_v_q501    <= RingReqInValidQ500H && !consume;
         req_rqr_q501  <= RingReqInRequestorQ500H;
         req_op_q501   <= RingReqInOpcodeQ500H;
         req_addr_q501 <= RingReqInAddressQ500H;
         req_data_q501 <= RingReqInDataQ500H;
         rsp_v_q501    <= RingRspInValidQ500H;
         rsp_rqr_q501  <= RingRspInRequestorQ500H;
         rsp_op_q501   <= RingRspInOpcodeQ500H;
         rsp_addr_q501 <= RingRspInAddressQ500H;
         rsp_data_q501 <= RingRspInDataQ500H;
         wr_en_q501    <= consume && is_wr && !addr_err;
         wr_idx_q501   <= idx;
         wr_data_q501  <= RingReqInDataQ500H;

         RingReqOutValidQ502H     <= req_v_q501;
         RingReqOutRequestorQ502H <= req_rqr_q501;
         RingReqOutOpcodeQ502H    <= req_op_q501;
         RingReqOutAddressQ502H   <= req_addr_q501;
         RingReqOutDataQ502H      <= req_data_q501;
         if (pop) begin
            RingRspOutValidQ502H     <= 1'b1;
            RingRspOutRequestorQ502H <= fifo_rqr[rd_ptr];
            RingRspOutOpcodeQ502H    <= fifo_op[rd_ptr];
            RingRspOutAddressQ502H   <= fifo_addr[rd_ptr];
            RingRspOutDataQ502H      <= fifo_data[rd_ptr];
         end else begin
            RingRspOutValidQ502H     <= rsp_v_q501;
            RingRspOutRequestorQ502H <= rsp_rqr_q501;
            RingRspOutOpcodeQ502H    <= rsp_op_q501;
            RingRspOutAddressQ502H   <= rsp_addr_q501;
            RingRspOutDataQ502H      <= rsp_data_q501;
         end

         if (consume) wr_ptr <= wr_ptr + 2'd1;
         if (pop)     rd_ptr <= rd_ptr + 2'd1;
         fifo_cnt <= fifo_cnt + {2'b00, consume} - {2'b00, pop};
      end
   end

   // Response FIFO storage; contents are don't-care until the pointers cover them.
   always_ff @(posedge QClk) begin
      if (consume && !RstQnnnH) begin
         fifo_rqr[wr_ptr]  <= RingReqInRequestorQ500H;
         fifo_op[wr_ptr]   <= is_wr ? OP_WR_RSP : OP_RD_RSP;
         fifo_addr[wr_ptr] <= RingReqInAddressQ500H;
         fifo_data[wr_ptr] <= push_data;
      end
   end

   // Local memory; contents deliberately survive reset.
   always_ff @(posedge QClk) begin
      if (wr_en_q501) mem[wr_idx_q501] <= wr_data_q501;
   end

endmodule

// File: tb/tb_ring_mem_responder.sv
// Testbench for ring_mem_responder. A per-slot plan holds the ingress values and the
// egress values expected two cycles later. The expected values are moved onto the
// scoreboard queues when the slot is driven. They are popped and compared when that
// slot reaches Q502.
module tb_ring_mem_responder;

   localparam logic [2:0] OP_RD     = 3'd1;
   localparam logic [2:0] OP_WR     = 3'd2;
   localparam logic [2:0] OP_RD_RSP = 3'd3;
   localparam logic [2:0] OP_WR_RSP = 3'd4;
   localparam logic [2:0] OP_OTHER  = 3'd6;

   typedef struct packed {
      logic        valid;
      logic [9:0]  rqr;
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
   } slot_t;

   typedef struct packed {
      slot_t ireq;
      slot_t irsp;
      slot_t ereq;
      slot_t ersp;
   } plan_t;

   logic        QClk = 1'b0;
   logic        RstQnnnH;
   logic [7:0]  CoreID;
   slot_t       req_in;
   slot_t       rsp_in;
   slot_t       req_out;
   slot_t       rsp_out;
   logic        ro_v, so_v;
   logic [9:0]  ro_r, so_r;
   logic [2:0]  ro_o, so_o;
   logic [31:0] ro_a, so_a, ro_d, so_d;

   plan_t plan[$];
   slot_t exp_req[$];
   slot_t exp_rsp[$];
   int    n_pass  = 0;
   int    n_total = 0;

   assign req_out = {ro_v, ro_r, ro_o, ro_a, ro_d};
   assign rsp_out = {so_v, so_r, so_o, so_a, so_d};

   ring_mem_responder dut (
      .QClk                    (QClk),
      .RstQnnnH                (RstQnnnH),
      .CoreID                  (CoreID),
      .RingReqInValidQ500H     (req_in.valid),
      .RingReqInRequestorQ500H (req_in.rqr),
      .RingReqInOpcodeQ500H    (req_in.op),
      .RingReqInAddressQ500H   (req_in.addr),
      .RingReqInDataQ500H      (req_in.data),
      .RingRspInValidQ500H     (rsp_in.valid),
      .RingRspInRequestorQ500H (rsp_in.rqr),
      .RingRspInOpcodeQ500H    (rsp_in.op),
      .RingRspInAddressQ500H   (rsp_in.addr),
      .RingRspInDataQ500H      (rsp_in.data),
      .RingReqOutValidQ502H    (ro_v),
      .RingReqOutRequestorQ502H(ro_r),
      .RingReqOutOpcodeQ502H   (ro_o),
      .RingReqOutAddressQ502H  (ro_a),
      .RingReqOutDataQ502H     (ro_d),
      .RingRspOutValidQ502H    (so_v),
      .RingRspOutRequestorQ502H(so_r),
      .RingRspOutOpcodeQ502H   (so_o),
      .RingRspOutAddressQ502H  (so_a),
      .RingRspOutDataQ502H     (so_d)
   );

   always #5 QClk = ~QClk;

   function automatic slot_t mk(input logic v, input logic [9:0] r, input logic [2:0] o,
                                input logic [31:0] a, input logic [31:0] d);
      return {v, r, o, a, d};
   endfunction

   function automatic slot_t busy_slot();
      return mk(1'b1, 10'($urandom), OP_RD_RSP, $urandom, $urandom);
   endfunction

   function automatic slot_t gone(input slot_t x);
      slot_t y;
      y = x;
      y.valid = 1'b0;
      return y;
   endfunction

   function automatic slot_t rsp_of(input slot_t r, input logic [2:0] o, input logic [31:0] d);
      return mk(1'b1, r.rqr, o, r.addr, d);
   endfunction

   function automatic logic [31:0] a_val(input int k);
      return 32'hA5A5_0000 + 32'(k);
   endfunction

   task automatic tick();
      @(posedge QClk);
      #1;
   endtask

   task automatic add(input slot_t ireq, input slot_t irsp, input slot_t ereq, input slot_t ersp);
      plan.push_back({ireq, irsp, ereq, ersp});
   endtask

   task automatic drive_next();
      plan_t p;
      if (plan.size() > 0) begin
         p = plan.pop_front();
         req_in = p.ireq;
         rsp_in = p.irsp;
         exp_req.push_back(p.ereq);
         exp_rsp.push_back(p.ersp);
      end else begin
         req_in = '0;
         rsp_in = '0;
      end
   endtask

   task automatic test_reset();
      RstQnnnH = 1'b1;
      for (int c = 0; c < 2; c++) begin
         req_in = {1'b1, 10'($urandom), 3'($urandom), 8'h05, 24'($urandom), $urandom};
         rsp_in = {1'b1, 10'($urandom), 3'($urandom), $urandom, $urandom};
         tick();
         n_total++;
         if (req_out !== '0 || rsp_out !== '0)
            $display("FAIL reset_hold cycle %0d: got req %h rsp %h expected all zero", c, req_out, rsp_out);
         else n_pass++;
      end
      RstQnnnH = 1'b0;
      req_in   = '0;
      rsp_in   = '0;
      tick();
      n_total++;
      if (req_out !== '0 || rsp_out !== '0)
         $display("FAIL reset_after: got req %h rsp %h expected all zero", req_out, rsp_out);
      else n_pass++;
   endtask

   task automatic test_write_read();
      slot_t w, r, w2, r2, er, es;
      int    n;
      w  = mk(1'b1, 10'h12A, OP_WR, 32'h0500_0010, 32'hCAFE_0001);
      r  = mk(1'b1, 10'h0B3, OP_RD, 32'h0500_0010, 32'h0);
      w2 = mk(1'b1, 10'h001, OP_WR, 32'h0500_00FC, 32'h1357_9BDF);
      r2 = mk(1'b1, 10'h002, OP_RD, 32'h0500_00FD, 32'h0);
      add(w,  '0, gone(w),  rsp_of(w,  OP_WR_RSP, 32'hCAFE_0001));
      add(r,  '0, gone(r),  rsp_of(r,  OP_RD_RSP, 32'hCAFE_0001));
      add(w2, '0, gone(w2), rsp_of(w2, OP_WR_RSP, 32'h1357_9BDF));
      add('0, '0, '0, '0);
      add(r2, '0, gone(r2), rsp_of(r2, OP_RD_RSP, 32'h1357_9BDF));
      add('0, '0, '0, '0);
      n = plan.size();
      for (int s = 0; s <= n; s++) begin
         drive_next();
         tick();
         if (s > 0) begin
            er = exp_req.pop_front();
            es = exp_rsp.pop_front();
            n_total++;
            if (req_out !== er) $display("FAIL write_read req slot %0d: got %h expected %h", s - 1, req_out, er);
            else n_pass++;
            n_total++;
            if (rsp_out !== es) $display("FAIL write_read rsp slot %0d: got %h expected %h", s - 1, rsp_out, es);
            else n_pass++;
         end
      end
   endtask

   task automatic test_pass_through();
      slot_t q0, q1, q2, q3, p0, p3, er, es;
      int    n;
      q0 = mk(1'b1, 10'h2C1, OP_RD,    32'h0300_0000, 32'hDEAD_BEEF);
      q1 = mk(1'b1, 10'h2C2, OP_OTHER, 32'h0500_0020, 32'h0000_1111);
      q2 = mk(1'b1, 10'h2C3, 3'd0,     32'h0500_0024, 32'h0000_2222);
      q3 = mk(1'b0, 10'h2C4, OP_WR,    32'h0500_0060, 32'h0000_3333);
      p0 = mk(1'b1, 10'h155, OP_RD_RSP, 32'h0700_0040, 32'h0BAD_F00D);
      p3 = mk(1'b0, 10'h3FF, OP_RD_RSP, 32'h1234_5678, 32'h9ABC_DEF0);
      add(q0, p0, q0, p0);
      add(q1, '0, q1, '0);
      add(q2, '0, q2, '0);
      add(q3, p3, q3, p3);
      add('0, '0, '0, '0);
      add('0, '0, '0, '0);
      n = plan.size();
      for (int s = 0; s <= n; s++) begin
         drive_next();
         tick();
         if (s > 0) begin
            er = exp_req.pop_front();
            es = exp_rsp.pop_front();
            n_total++;
            if (req_out !== er) $display("FAIL pass_through req slot %0d: got %h expected %h", s - 1, req_out, er);
            else n_pass++;
            n_total++;
            if (rsp_out !== es) $display("FAIL pass_through rsp slot %0d: got %h expected %h", s - 1, rsp_out, es);
            else n_pass++;
         end
      end
   endtask

   task automatic test_back_to_back();
      slot_t w, r, er, es;
      int    n;
      for (int k = 0; k < 4; k++) begin
         w = mk(1'b1, 10'(16 + k), OP_WR, 32'h0500_0040 + 32'(4 * k), a_val(k));
         add(w, '0, gone(w), rsp_of(w, OP_WR_RSP, a_val(k)));
      end
      r = mk(1'b1, 10'h030, OP_RD, 32'h0500_0048, 32'h0);
      add(r, '0, gone(r), rsp_of(r, OP_RD_RSP, a_val(2)));
      r = mk(1'b1, 10'h031, OP_RD, 32'h0500_004C, 32'h0);
      add(r, '0, gone(r), rsp_of(r, OP_RD_RSP, a_val(3)));
      add('0, '0, '0, '0);
      n = plan.size();
      for (int s = 0; s <= n; s++) begin
         drive_next();
         tick();
         if (s > 0) begin
            er = exp_req.pop_front();
            es = exp_rsp.pop_front();
            n_total++;
            if (req_out !== er) $display("FAIL back_to_back req slot %0d: got %h expected %h", s - 1, req_out, er);
            else n_pass++;
            n_total++;
            if (rsp_out !== es) $display("FAIL back_to_back rsp slot %0d: got %h expected %h", s - 1, rsp_out, es);
            else n_pass++;
         end
      end
   endtask

   task automatic test_fifo_full();
      slot_t rds[4];
      slot_t b, r, er, es;
      int    n;
      b = busy_slot();
      add('0, b, '0, b);
      for (int k = 0; k < 4; k++) begin
         rds[k] = mk(1'b1, 10'(64 + k), OP_RD, 32'h0500_0040 + 32'(4 * k), $urandom);
         b = busy_slot();
         add(rds[k], b, gone(rds[k]), b);
      end
      r = mk(1'b1, 10'h050, OP_RD, 32'h0500_0040, 32'h0);
      b = busy_slot();
      add(r, b, r, b);
      for (int k = 0; k < 4; k++) add('0, '0, '0, rsp_of(rds[k], OP_RD_RSP, a_val(k)));
      add('0, '0, '0, '0);
      n = plan.size();
      for (int s = 0; s <= n; s++) begin
         drive_next();
         tick();
         if (s > 0) begin
            er = exp_req.pop_front();
            es = exp_rsp.pop_front();
            n_total++;
            if (req_out !== er) $display("FAIL fifo_full req slot %0d: got %h expected %h", s - 1, req_out, er);
            else n_pass++;
            n_total++;
            if (rsp_out !== es) $display("FAIL fifo_full rsp slot %0d: got %h expected %h", s - 1, rsp_out, es);
            else n_pass++;
         end
      end
   endtask

   task automatic test_simultaneous();
      slot_t rds[4];
      slot_t b, w, x, r, er, es;
      int    n;
      b = busy_slot();
      add('0, b, '0, b);
      for (int k = 0; k < 4; k++) begin
         rds[k] = mk(1'b1, 10'(128 + k), OP_RD, 32'h0500_0040 + 32'(4 * k), 32'h0);
         b = busy_slot();
         add(rds[k], b, gone(rds[k]), b);
      end
      add('0, '0, '0, rsp_of(rds[0], OP_RD_RSP, a_val(0)));
      w = mk(1'b1, 10'h0A0, OP_WR, 32'h0500_0050, 32'h5555_AAAA);
      b = busy_slot();
      add(w, b, gone(w), b);
      x = mk(1'b1, 10'h0A1, OP_RD, 32'h0500_0040, 32'h0);
      b = busy_slot();
      add(x, b, x, b);
      for (int k = 1; k < 4; k++) add('0, '0, '0, rsp_of(rds[k], OP_RD_RSP, a_val(k)));
      add('0, '0, '0, rsp_of(w, OP_WR_RSP, 32'h5555_AAAA));
      add('0, '0, '0, '0);
      r = mk(1'b1, 10'h0A2, OP_RD, 32'h0500_0050, 32'h0);
      add(r, '0, gone(r), rsp_of(r, OP_RD_RSP, 32'h5555_AAAA));
      add('0, '0, '0, '0);
      n = plan.size();
      for (int s = 0; s <= n; s++) begin
         drive_next();
         tick();
         if (s > 0) begin
            er = exp_req.pop_front();
            es = exp_rsp.pop_front();
            n_total++;
            if (req_out !== er) $display("FAIL simultaneous req slot %0d: got %h expected %h", s - 1, req_out, er);
            else n_pass++;
            n_total++;
            if (rsp_out !== es) $display("FAIL simultaneous rsp slot %0d: got %h expected %h", s - 1, rsp_out, es);
            else n_pass++;
         end
      end
   endtask

   task automatic test_mid_reset();
      slot_t b, r, er, es;
      int    n;
      b = busy_slot();
      add('0, b, '0, b);
      for (int k = 0; k < 2; k++) begin
         r = mk(1'b1, 10'(200 + k), OP_RD, 32'h0500_0040 + 32'(4 * k), 32'h0);
         b = busy_slot();
         add(r, b, gone(r), b);
      end
      n = plan.size();
      for (int s = 0; s <= n; s++) begin
         drive_next();
         tick();
         if (s > 0) begin
            er = exp_req.pop_front();
            es = exp_rsp.pop_front();
            n_total++;
            if (req_out !== er) $display("FAIL mid_reset_fill req slot %0d: got %h expected %h", s - 1, req_out, er);
            else n_pass++;
            n_total++;
            if (rsp_out !== es) $display("FAIL mid_reset_fill rsp slot %0d: got %h expected %h", s - 1, rsp_out, es);
            else n_pass++;
         end
      end
      RstQnnnH = 1'b1;
      tick();
      RstQnnnH = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_total++;
         if (req_out !== '0 || rsp_out !== '0)
            $display("FAIL mid_reset_drop cycle %0d: got req %h rsp %h expected all zero", c, req_out, rsp_out);
         else n_pass++;
      end
      r = mk(1'b1, 10'h0C0, OP_RD, 32'h0500_0040, 32'h0);
      add(r, '0, gone(r), rsp_of(r, OP_RD_RSP, a_val(0)));
      add('0, '0, '0, '0);
      n = plan.size();
      for (int s = 0; s <= n; s++) begin
         drive_next();
         tick();
         if (s > 0) begin
            er = exp_req.pop_front();
            es = exp_rsp.pop_front();
            n_total++;
            if (req_out !== er) $display("FAIL mid_reset_mem req slot %0d: got %h expected %h", s - 1, req_out, er);
            else n_pass++;
            n_total++;
            if (rsp_out !== es) $display("FAIL mid_reset_mem rsp slot %0d: got %h expected %h", s - 1, rsp_out, es);
            else n_pass++;
         end
      end
   endtask

   task automatic test_addr_range();
      slot_t q0, q1, q2, er, es;
      int    n;
`ifdef RING_RSP_ADDR_CHK_EN
      q0 = mk(1'b1, 10'h0E0, OP_RD, 32'h0501_0000, 32'h0);
      q1 = mk(1'b1, 10'h0E1, OP_WR, 32'h0501_0040, 32'hFFFF_0000);
      q2 = mk(1'b1, 10'h0E2, OP_RD, 32'h0500_0040, 32'h0);
      add(q0, '0, gone(q0), rsp_of(q0, OP_RD_RSP, 32'hBADA_DD00));
      add(q1, '0, gone(q1), rsp_of(q1, OP_WR_RSP, 32'hBADA_DD00));
      add(q2, '0, gone(q2), rsp_of(q2, OP_RD_RSP, a_val(0)));
`else
      q0 = mk(1'b1, 10'h0E0, OP_WR, 32'h05AB_CD44, 32'h7777_1111);
      q1 = mk(1'b1, 10'h0E1, OP_RD, 32'h0500_0044, 32'h0);
      q2 = mk(1'b1, 10'h0E2, OP_RD, 32'h05FF_FF40, 32'h0);
      add(q0, '0, gone(q0), rsp_of(q0, OP_WR_RSP, 32'h7777_1111));
      add(q1, '0, gone(q1), rsp_of(q1, OP_RD_RSP, 32'h7777_1111));
      add(q2, '0, gone(q2), rsp_of(q2, OP_RD_RSP, a_val(0)));
`endif
      add('0, '0, '0, '0);
      n = plan.size();
      for (int s = 0; s <= n; s++) begin
         drive_next();
         tick();
         if (s > 0) begin
            er = exp_req.pop_front();
            es = exp_rsp.pop_front();
            n_total++;
            if (req_out !== er) $display("FAIL addr_range req slot %0d: got %h expected %h", s - 1, req_out, er);
            else n_pass++;
            n_total++;
            if (rsp_out !== es) $display("FAIL addr_range rsp slot %0d: got %h expected %h", s - 1, rsp_out, es);
            else n_pass++;
         end
      end
   endtask

   initial begin
      RstQnnnH = 1'b1;
      CoreID   = 8'h05;
      req_in   = '0;
      rsp_in   = '0;
      test_reset();
      test_write_read();
      test_pass_through();
      test_back_to_back();
      test_fifo_full();
      test_simultaneous();
      test_mid_reset();
      test_addr_range();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ring_mem_responder.md
RING_MEM_RESPONDER -- requirements
Module: ring_mem_responder

Interface
REQ-001 SHALL have port QClk, input, 1 bit: the single clock; all flops rise on it.
REQ-002 SHALL have port RstQnnnH, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port CoreID, input, 8 bits: ring stop ID; a request targets this block when Address[31:24]==CoreID.
REQ-004 SHALL have ports RingReqIn{Valid,Requestor,Opcode,Address,Data}Q500H, input, 1/10/t_opcode/32/32 bits: request ring ingress.
REQ-005 SHALL have ports RingRspIn{Valid,Requestor,Opcode,Address,Data}Q500H, input, 1/10/t_opcode/32/32 bits: response ring ingress.
REQ-006 SHALL have ports RingReqOut{Valid,Requestor,Opcode,Address,Data}Q502H, output, 1/10/t_opcode/32/32 bits: request ring egress.
REQ-007 SHALL have ports RingRspOut{Valid,Requestor,Opcode,Address,Data}Q502H, output, 1/10/t_opcode/32/32 bits: response ring egress.

Function
REQ-008 SHALL register both rings through two flop stages (Q500->Q501->Q502); fixed latency 2 cycles, one slot per cycle, no stalls.
REQ-009 SHALL hold a 64x32 local memory indexed by Address[7:2]; Address[1:0] ignored.
REQ-010 SHALL consume a Q500 request when Valid=1, Address[31:24]==CoreID, Opcode is RD or WR, and the response FIFO is not full (count, including a same-cycle pop).
REQ-011 SHALL drive RingReqOutValidQ502H=0 for a consumed slot; other fields pass unchanged.
REQ-012 SHALL pass a request unchanged when the FIFO is full, the opcode is not RD/WR, or the request targets another ID; the request then recirculates.
REQ-013 SHALL write Data into memory at Q501 for a consumed WR.
REQ-014 SHALL read memory for a consumed RD, with a same-cycle-written location returning the new data.
REQ-015 SHALL push one response per consumed request into a 4-entry FIFO at Q501. Opcode SHALL be RD_RSP or WR_RSP. Requestor and Address SHALL be copied. Data SHALL be the read data for RD, or the write data echoed for WR.
REQ-016 SHALL fill an empty response slot: when the Q501 response-ring slot has Valid=0 and the FIFO is non-empty, the FIFO head is popped and driven at Q502.
REQ-017 SHALL forward occupied response-ring slots unchanged and never overwrite them; the FIFO waits.
REQ-018 SHALL support push and pop in the same cycle; on a full FIFO this is allowed and the count is unchanged.
REQ-019 SHALL wrap FIFO pointers modulo 4; 3-bit count 0..4.
REQ-020 SHALL emit responses in request-consumption order.

Reset
REQ-021 SHALL, with RstQnnnH=1 at a QClk edge, clear all pipeline Valid flops, FIFO pointers and count; all Q502 output fields read 0.
REQ-022 SHALL drop a mid-operation reset's in-flight requests and queued responses; memory contents are not reset.
REQ-023 SHALL accept ring traffic on the first edge after RstQnnnH deasserts.

Configuration
REQ-024 SHALL provide macro RING_RSP_ADDR_CHK_EN for the range check.
- Defined: a targeted RD/WR with Address[23:8]!=0 is consumed without a memory access, and the response carries Data=32'hBADA_DD00.
- Undefined: Address[23:8] is ignored and memory is aliased.

Verification
REQ-025 Reset: RstQnnnH=1 for 2 cycles with random ingress -> all Out Valid=0 and all fields 0 during reset and one cycle after.
REQ-026 Write/read: CoreID=8'h5; WR Addr=32'h0500_0010 Data=32'hCAFE_0001, then RD Addr=32'h0500_0010 -> ReqOut slots Valid=0; two RspOut slots at +2 cycles: WR_RSP Data=CAFE_0001, then RD_RSP Data=CAFE_0001, Requestor matching.
REQ-027 Pass-through: request Addr=32'h0300_0000 and a valid response slot -> both appear unchanged at Q502 after exactly 2 cycles.
REQ-028 FIFO full: response ring held fully occupied, 5 targeted RDs -> first 4 consumed; 5th passes through with Valid=1. After the ring frees, 4 responses drain in order.
REQ-029 Simultaneous events: FIFO at 4, an empty response slot and a targeted WR in the same cycle -> pop and push both occur, count stays 4, WR consumed.
REQ-030 Range check (RING_RSP_ADDR_CHK_EN defined): RD Addr=32'h0501_0000 -> RD_RSP Data=32'hBADA_DD00, memory unchanged.
